// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } serial_state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; the only arithmetic cell used by serial_adder.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full adder reused LSB-first
// over WIDTH cycles, valid/ready handshake on operands and result.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_e    state;
  serial_state_e    state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic             fa_sum_c;
  logic             fa_cout_c;
  logic             last_bit_c;
  logic             accept_c;

  full_adder_1bit u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry_q),
    .sum_c  (fa_sum_c),
    .cout_c (fa_cout_c)
  );

  assign o_ready    = (state == S_IDLE);
  assign accept_c   = i_valid & o_ready;
  assign last_bit_c = (cnt == CNT_LAST);

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (accept_c)   state_d = S_RUN;
      S_RUN:   if (last_bit_c) state_d = S_DONE;
      S_DONE:  if (i_ready)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, bit counter, shift registers and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry_q    <= 1'b0;
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state   <= state_d;
      o_valid <= (state_d == S_DONE);
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            // Subtraction as A + ~B + 1; external carry-in is ignored.
            a_sh    <= i_a;
            b_sh    <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub ? 1'b1 : i_carry;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= {fa_sum_c, sum_sh[WIDTH-1:1]};
          carry_q <= fa_cout_c;
          if (last_bit_c) begin
            cnt        <= '0;
            o_sum      <= {fa_sum_c, sum_sh[WIDTH-1:1]};
            o_carry    <= fa_cout_c;
            // carry_q here is the carry into the MSB
            o_overflow <= carry_q ^ fa_cout_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder/subtractor that reuses one full_adder_1bit instance over WIDTH cycles, processing LSB first.
- A registered carry flip-flop feeds the adder's carry-out back into its carry-in on the next cycle.
- Targets area-constrained or multi-cycle datapaths (e.g. a multi-cycle ALU option) where a full ripple-carry adder is too large.
- Uses a valid/ready handshake on both the input and the output side.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 2.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_carry  input  1  carry-in for addition; ignored when i_sub=1.
- i_sub  input  1  1 = compute A - B (A + ~B + 1).
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_sum  output  WIDTH  result.
- o_carry  output  1  carry-out of the MSB. For subtraction, 1 means no borrow.
- o_overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- States (shared enum): S_IDLE, S_RUN, S_DONE.
- Reset (i_rst_n=0 at an edge):
  - state <= S_IDLE; bit counter, shift registers and carry flop <= 0.
  - o_valid=0, o_sum=0, o_carry=0, o_overflow=0.
  - Reset applies from any state, including mid-S_RUN; any in-flight operation is discarded with no partial result.
- o_ready is combinational: o_ready = (state == S_IDLE). o_valid is registered: o_valid = (state == S_DONE).
- Acceptance in S_IDLE (i_valid & o_ready at an edge):
  - Latch a_sh <= i_a.
  - Latch b_sh <= i_sub ? ~i_b : i_b.
  - Latch carry_q <= i_sub ? 1 : i_carry.
  - Set cnt <= 0; state <= S_RUN.
- S_RUN, each edge:
  - Adder inputs: a_sh[0], b_sh[0], carry_q.
  - a_sh and b_sh shift right by 1.
  - The adder's sum bit shifts into the MSB of sum_sh (sum_sh shifts right).
  - carry_q <= adder carry-out; cnt <= cnt + 1.
- Last bit (cnt == WIDTH-1), same edge:
  - o_sum <= final sum_sh value, including that bit.
  - o_carry <= adder carry-out.
  - o_overflow <= carry_q ^ adder carry-out.
  - state <= S_DONE.
- Latency: acceptance edge E0; o_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance. Throughput: one operation per WIDTH+2 cycles minimum.
- S_DONE:
  - o_sum, o_carry and o_overflow are held stable while i_ready=0.
  - On an edge with i_ready=1: state <= S_IDLE. o_ready rises in the following cycle.
- Result registers keep the last result after leaving S_DONE until the next completion or reset; they are meaningful only while o_valid=1.
- i_valid outside S_IDLE is ignored; operands are not captured.
- Operand inputs may change freely after acceptance without affecting the result.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg: typedef enum logic [1:0] serial_state_e {S_IDLE, S_RUN, S_DONE}.
- Exactly one full_adder_1bit instance as the sole arithmetic sub-module. No other adder logic in the block.
- FSM, counter and shift registers live in a single always_ff.

Test Plan:
- WIDTH=8, A=0x35, B=0x1C, carry=0, sub=0 -> o_sum=0x51, o_carry=0, o_overflow=0; o_valid high exactly 8 cycles after the acceptance edge.
- A=0xFF, B=0x01 -> 0x00, carry 1, ovf 0. A=0x7F, B=0x01 -> 0x80, carry 0, ovf 1. A=0xFF, B=0xFF, carry=1 -> 0xFF, carry 1, ovf 0.
- sub=1, A=0x10, B=0x20 -> 0xF0, carry 0 (borrow), ovf 0. sub=1, A=0x80, B=0x01 -> 0x7F, carry 1, ovf 1. i_carry=1 during subtraction has no effect.
- Backpressure: hold i_ready=0 for 5 cycles in S_DONE while pulsing i_valid with new operands -> outputs stable, o_ready=0, new operands not captured; release i_ready -> o_valid falls and o_ready rises next cycle.
- Reset mid-operation: assert i_rst_n=0 for one edge after 3 bits processed -> next cycle o_valid=0, o_sum=0, o_ready=1; a following A=0x35, B=0x1C operation returns 0x51.
- Back-to-back: i_valid held high with i_ready=1 continuously -> operations complete every WIDTH+2 cycles with correct, non-corrupted results.
